mem_write_checker: RTL and testbench

- Synthesizable scoreboard on the pipelined core's data-memory write port (MemWriteM/DataAdrM/WriteDataM).
- Holds a programmable ordered list of expected (address, data) stores and flags PASS, FAIL on mismatch, or FAIL on timeout.
- Instantiated beside the core top in benches and FPGA builds.
- Generalises a single hard-wired address/value check to N entries, configurable widths, run-length and a watchdog.

---
 rtl/mem_write_checker.sv | 212 +++++++++++++++++++++
 tb/tb_mem_write_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: scoreboard on the core's data-memory write port.
// Holds an ordered table of expected (address, data) stores. Once armed, it
// watches the store bus and ends in PASS (all entries matched in order), or
// in FAIL on a data mismatch or on watchdog expiry.
// Optional build macro: MEM_WRITE_CHECKER_TRACE_EN keeps the offending store
// data of a mismatch on last_bad_data. Without it that output is constant 0.
//
// Handshake: there is no valid/ready pair. 'start' is a one-cycle request
// accepted in IDLE, PASS or FAIL (ignored in RUN). busy is high while
// checking. done is high (sticky) once a verdict exists. pass/fail and
// fail_code describe that verdict until the next accepted start or reset.
`default_nettype none

module mem_write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 8,
    parameter int TIMEOUT_W   = 16,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_write,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_wdata,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 start,
    input  logic [CNT_W-1:0]     run_len,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [IDX_W-1:0]     fail_index,
    output logic [CNT_W-1:0]     match_count,
    output logic [TIMEOUT_W-1:0] cycle_count,
    output logic [DATA_W-1:0]    last_bad_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] NUM_ENT_C = CNT_W'(NUM_ENTRIES);
    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     match_q, match_d;
    logic [CNT_W-1:0]     runlen_q, runlen_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] cyc_q, cyc_d;
    logic [1:0]           code_q, code_d;
    logic [IDX_W-1:0]     fidx_q, fidx_d;

    logic [ADDR_W-1:0]    tbl_addr_q [NUM_ENTRIES];
    logic [DATA_W-1:0]    tbl_data_q [NUM_ENTRIES];

    logic                 addr_hit;
    logic                 data_ok;
    logic                 cfg_ok;
    int unsigned          cfg_idx_int;

    // Table writes are accepted only outside RUN and only for in-range indices.
    always_comb begin
        cfg_idx_int = 32'(cfg_idx);
        cfg_ok      = cfg_we && (state_q != ST_RUN) && (cfg_idx_int < NUM_ENTRIES);
    end

    // Expected-store table; cleared by reset so a fresh build starts from zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_data_q[cfg_idx] <= cfg_data;
        end
    end

    // Compare the live store against the entry currently awaited.
    always_comb begin
        addr_hit = mem_write && (mem_addr == tbl_addr_q[ptr_q]);
        data_ok  = (mem_wdata == tbl_data_q[ptr_q]);
    end

    // Next-state logic: arming, in-order matching, and the watchdog.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        match_d  = match_q;
        runlen_d = runlen_q;
        tmo_d    = tmo_q;
        cyc_d    = cyc_q;
        code_d   = code_q;
        fidx_d   = fidx_q;
        unique case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    ptr_d    = '0;
                    match_d  = '0;
                    cyc_d    = '0;
                    code_d   = CODE_NONE;
                    fidx_d   = '0;
                    tmo_d    = timeout;
                    runlen_d = (run_len > NUM_ENT_C) ? NUM_ENT_C : run_len;
                    state_d  = (run_len == '0) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + TIMEOUT_W'(1);
                end
                if (addr_hit) begin
                    if (data_ok) begin
                        match_d = match_q + CNT_W'(1);
                        ptr_d   = ptr_q + IDX_W'(1);
                        if (match_d == runlen_q) begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        state_d = ST_FAIL;
                        code_d  = CODE_MISMATCH;
                        fidx_d  = ptr_q;
                    end
                end
                // A store verdict on this edge takes precedence over the watchdog.
                if ((state_d == ST_RUN) && (tmo_q != '0) &&
                    ((cyc_q + TIMEOUT_W'(1)) == tmo_q)) begin
                    state_d = ST_FAIL;
                    code_d  = CODE_TIMEOUT;
                    fidx_d  = ptr_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            match_q  <= '0;
            runlen_q <= '0;
            tmo_q    <= '0;
            cyc_q    <= '0;
            code_q   <= CODE_NONE;
            fidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            match_q  <= match_d;
            runlen_q <= runlen_d;
            tmo_q    <= tmo_d;
            cyc_q    <= cyc_d;
            code_q   <= code_d;
            fidx_q   <= fidx_d;
        end
    end

`ifdef MEM_WRITE_CHECKER_TRACE_EN
    logic [DATA_W-1:0] bad_q, bad_d;

    // Capture the offending data on a mismatch; cleared on every accepted start.
    always_comb begin
        bad_d = bad_q;
        if ((state_q != ST_RUN) && start) begin
            bad_d = '0;
        end else if ((state_q == ST_RUN) && addr_hit && !data_ok) begin
            bad_d = mem_wdata;
        end
    end

    // Offending-data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_q <= '0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign last_bad_data = bad_q;
`else
    assign last_bad_data = '0;
`endif

    assign busy        = (state_q == ST_RUN);
    assign pass        = (state_q == ST_PASS);
    assign fail        = (state_q == ST_FAIL);
    assign done        = pass | fail;
    assign fail_code   = code_q;
    assign fail_index  = fidx_q;
    assign match_count = match_q;
    assign cycle_count = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker with default parameters (32/32/8/16).
// Driver tasks issue directed stores; each expected verdict is pushed to
// exp_q before its stimulus, and a negedge monitor pops and compares it
// whenever the checker presents a new verdict.
`timescale 1ns/1ps

module tb_mem_write_checker;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;
    localparam int TW     = 16;
    // record: pass, fail, fail_code, fail_index, match_count, cycle_count, last_bad_data
    localparam int W = 1 + 1 + 2 + IDX_W + CNT_W + TW + DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              start;
    logic [CNT_W-1:0]  run_len;
    logic [TW-1:0]     timeout;
    logic              busy, done, pass, fail;
    logic [1:0]        fail_code;
    logic [IDX_W-1:0]  fail_index;
    logic [CNT_W-1:0]  match_count;
    logic [TW-1:0]     cycle_count;
    logic [DATA_W-1:0] last_bad_data;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic done_prev = 1'b0;
    logic start_prev = 1'b0;

    mem_write_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ENTRIES(8), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .run_len(run_len), .timeout(timeout),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_index(fail_index),
        .match_count(match_count), .cycle_count(cycle_count),
        .last_bad_data(last_bad_data)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] trace(input logic [DATA_W-1:0] d);
`ifdef MEM_WRITE_CHECKER_TRACE_EN
        return d;
`else
        return '0;
`endif
    endfunction

    function automatic logic [W-1:0] outs();
        return {pass, fail, fail_code, fail_index, match_count, cycle_count, last_bad_data};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input int len, input int tmo);
        start = 1'b1; run_len = CNT_W'(len); timeout = TW'(tmo);
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_write = 1'b1; mem_addr = a; mem_wdata = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic expect_res(input logic p, input logic f, input logic [1:0] code,
                              input int fidx, input int mc, input int cyc,
                              input logic [DATA_W-1:0] bad);
        exp_q.push_back({p, f, code, IDX_W'(fidx), CNT_W'(mc), TW'(cyc), bad});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // A verdict is new when done rises, or when done stays high across an accepted start.
    always @(negedge clk) begin
        if (reset) begin
            done_prev  <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            if (done && (!done_prev || start_prev)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL verdict_unexpected: got 0x%0h with no expected entry", outs());
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (outs() !== e) begin
                        n_bad++;
                        $display("FAIL verdict {pass,fail,code,idx,match,cyc,bad}: got 0x%0h expected 0x%0h",
                                 outs(), e);
                    end
                end
            end
            done_prev  <= done;
            start_prev <= start;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        reset = 1'b1; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; run_len = '0; timeout = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, outs()}), 64'd0);
        reset = 1'b0;
        tick();

        // single entry, match after 3 idle cycles
        cfg(0, 32'd128, 32'd254);
        expect_res(1'b1, 1'b0, 2'd0, 0, 1, 4, '0);
        arm(1, 0);
        check("busy_after_start", 64'({busy, done}), 64'b10);
        repeat (3) tick();
        store(32'd128, 32'd254);
        tick();
        // PASS is sticky: bus activity ignored
        store(32'd128, 32'd1);
        check("sticky_pass", 64'({pass, fail, match_count}), 64'({1'b1, 1'b0, 4'd1}));

        // re-arm from PASS clears counters, then mismatch
        arm(1, 0);
        check("rearm_cleared", 64'({busy, done, match_count, cycle_count, fail_code}), 64'({1'b1, 1'b0, 4'd0, 16'd0, 2'd0}));
        expect_res(1'b0, 1'b1, 2'd1, 0, 0, 1, trace(32'd255));
        store(32'd128, 32'd255);
        tick();

        // three-entry run with a stray store first
        cfg(0, 32'd100, 32'd7);
        cfg(1, 32'd104, 32'd9);
        cfg(2, 32'd128, 32'd254);
        expect_res(1'b1, 1'b0, 2'd0, 0, 3, 4, '0);
        arm(3, 0);
        store(32'd200, 32'd1);
        store(32'd100, 32'd7);
        store(32'd104, 32'd9);
        store(32'd128, 32'd254);
        tick();

        // same, second entry data wrong
        expect_res(1'b0, 1'b1, 2'd1, 1, 1, 3, trace(32'd8));
        arm(3, 0);
        store(32'd200, 32'd1);
        store(32'd100, 32'd7);
        store(32'd104, 32'd8);
        tick();

        // watchdog with no stores
        cfg(0, 32'd128, 32'd254);
        expect_res(1'b0, 1'b1, 2'd2, 0, 0, 10, '0);
        arm(1, 10);
        repeat (12) tick();

        // matching store on the tenth RUN cycle beats the watchdog
        expect_res(1'b1, 1'b0, 2'd0, 0, 1, 10, '0);
        arm(1, 10);
        repeat (9) tick();
        store(32'd128, 32'd254);
        tick();

        // run_len = 0 from PASS -> PASS next cycle with cleared counters
        expect_res(1'b1, 1'b0, 2'd0, 0, 0, 0, '0);
        arm(0, 0);
        tick();

        // run_len above table depth clamps to 8
        for (int i = 0; i < 8; i++) cfg(i, 32'h1000 + 32'(i * 16), 32'(i * 3 + 5));
        expect_res(1'b1, 1'b0, 2'd0, 0, 8, 8, '0);
        arm(15, 0);
        for (int i = 0; i < 8; i++) store(32'h1000 + 32'(i * 16), 32'(i * 3 + 5));
        tick();

        // start and cfg_we during RUN are ignored
        cfg(0, 32'd128, 32'd254);
        expect_res(1'b1, 1'b0, 2'd0, 0, 1, 3, '0);
        arm(1, 0);
        arm(0, 0);
        cfg(0, 32'd300, 32'd5);
        store(32'd128, 32'd254);
        tick();
        expect_res(1'b1, 1'b0, 2'd0, 0, 1, 1, '0);
        arm(1, 0);
        store(32'd128, 32'd254);
        tick();

        // asynchronous reset mid-RUN
        arm(1, 0);
        repeat (2) tick();
        #3 reset = 1'b1;
        #1 check("async_reset_outputs", 64'({busy, done, outs()}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        // table cleared by reset: entry 0 is now (0,0)
        expect_res(1'b1, 1'b0, 2'd0, 0, 1, 1, '0);
        arm(1, 0);
        store(32'd0, 32'd0);
        tick();

        // drain with a bound
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL verdict_timeout: %0d expected verdicts never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
